// File: rtl/hbridge_pwm_driver.sv
// hbridge_pwm_driver
// Two-channel H-bridge driver. It synchronises the upstream direction word and
// enables, then runs one soft-start FSM per channel. Each FSM inserts a bridge-off
// dead interval on every stop or reversal. One free-running counter generates
// PWM for both channels. Each channel's duty reaches the comparator through a
// shadow register that updates only at the counter wrap.
// Channel index 1 is channel A (bits [3:2]); index 0 is channel B (bits [1:0]).

module hbridge_pwm_driver #(
  parameter int PWM_BITS    = 8,
  parameter int DUTY_MAX    = 200,
  parameter int RAMP_STEP   = 8,
  parameter int RAMP_DIV    = 1000,
  parameter int DEAD_CYCLES = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] motor_in,
  input  logic [1:0] motor_en,
  output logic [3:0] hb_dir,
  output logic [1:0] hb_pwm,
  output logic [3:0] ch_state
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RAMP = 2'b01;
  localparam logic [1:0] ST_RUN  = 2'b10;
  localparam logic [1:0] ST_DEAD = 2'b11;

  localparam int PRESC_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int DEAD_W  = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

  localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(RAMP_DIV - 1);
  localparam logic [DEAD_W-1:0]   DEAD_LAST  = DEAD_W'(DEAD_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] DUTY_TOP   = PWM_BITS'(DUTY_MAX);
  localparam logic [PWM_BITS:0]   STEP_WIDE  = (PWM_BITS + 1)'(RAMP_STEP);
  localparam logic [PWM_BITS-1:0] PWM_TOP    = {PWM_BITS{1'b1}};

  // Saturating ramp increment; the extra bit keeps the sum from wrapping.
  function automatic logic [PWM_BITS-1:0] ramp_next(input logic [PWM_BITS-1:0] duty);
    logic [PWM_BITS:0] sum;
    sum = {1'b0, duty} + STEP_WIDE;
    if (sum >= {1'b0, DUTY_TOP}) begin
      ramp_next = DUTY_TOP;
    end else begin
      ramp_next = sum[PWM_BITS-1:0];
    end
  endfunction

  logic [3:0]          in_meta_r, in_sync_r;
  logic [1:0]          en_meta_r, en_sync_r;
  logic [PWM_BITS-1:0] pwm_cnt_r;

  logic [1:0]          state_r    [2];
  logic [1:0]          state_s    [2];
  logic [1:0]          dir_r      [2];
  logic [1:0]          dir_s      [2];
  logic [PWM_BITS-1:0] duty_r     [2];
  logic [PWM_BITS-1:0] duty_s     [2];
  logic [PRESC_W-1:0]  presc_r    [2];
  logic [PRESC_W-1:0]  presc_s    [2];
  logic [DEAD_W-1:0]   dead_r     [2];
  logic [DEAD_W-1:0]   dead_s     [2];
  logic [PWM_BITS-1:0] duty_act_r [2];
  logic [PWM_BITS-1:0] duty_act_s [2];

  logic [3:0] hb_dir_r, hb_dir_s;
  logic [1:0] hb_pwm_r, hb_pwm_s;

  logic [1:0]          pair_s;
  logic                en_s;
  logic                drive_s;
  logic [PWM_BITS-1:0] stepped_s;

  // Two-flop synchroniser for the asynchronous upstream command inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_meta_r <= 4'b0000;
      in_sync_r <= 4'b0000;
      en_meta_r <= 2'b00;
      en_sync_r <= 2'b00;
    end else begin
      in_meta_r <= motor_in;
      in_sync_r <= in_meta_r;
      en_meta_r <= motor_en;
      en_sync_r <= en_meta_r;
    end
  end

  // Free-running PWM counter shared by both channels; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_r <= {PWM_BITS{1'b0}};
    end else begin
      pwm_cnt_r <= pwm_cnt_r + PWM_BITS'(1);
    end
  end

  // Per-channel next-state, ramp, dead-time and PWM output decode.
  always_comb begin
    pair_s    = 2'b00;
    en_s      = 1'b0;
    drive_s   = 1'b0;
    stepped_s = {PWM_BITS{1'b0}};
    hb_dir_s  = 4'b0000;
    hb_pwm_s  = 2'b00;
    for (int ch = 0; ch < 2; ch++) begin
      pair_s         = in_sync_r[2*ch +: 2];
      en_s           = en_sync_r[ch];
      state_s[ch]    = state_r[ch];
      dir_s[ch]      = dir_r[ch];
      duty_s[ch]     = duty_r[ch];
      presc_s[ch]    = presc_r[ch];
      dead_s[ch]     = dead_r[ch];
      duty_act_s[ch] = duty_act_r[ch];
      stepped_s      = ramp_next(duty_r[ch]);

      case (state_r[ch])
        ST_IDLE: begin
          duty_s[ch]  = {PWM_BITS{1'b0}};
          presc_s[ch] = {PRESC_W{1'b0}};
          dead_s[ch]  = {DEAD_W{1'b0}};
          if (en_s && (pair_s == 2'b10 || pair_s == 2'b01)) begin
            state_s[ch] = ST_RAMP;
            dir_s[ch]   = pair_s;
          end else begin
            state_s[ch] = ST_IDLE;
          end
        end
        ST_RAMP, ST_RUN: begin
          if (!en_s || (pair_s != dir_r[ch])) begin
            // Stop code, reversal or disable all collapse into one dead entry.
            state_s[ch] = ST_DEAD;
            duty_s[ch]  = {PWM_BITS{1'b0}};
            presc_s[ch] = {PRESC_W{1'b0}};
            dead_s[ch]  = {DEAD_W{1'b0}};
          end else if (state_r[ch] == ST_RUN) begin
            duty_s[ch] = DUTY_TOP;
          end else if (presc_r[ch] == PRESC_LAST) begin
            presc_s[ch] = {PRESC_W{1'b0}};
            duty_s[ch]  = stepped_s;
            if (stepped_s == DUTY_TOP) begin
              state_s[ch] = ST_RUN;
            end else begin
              state_s[ch] = ST_RAMP;
            end
          end else begin
            presc_s[ch] = presc_r[ch] + PRESC_W'(1);
          end
        end
        ST_DEAD: begin
          // Inputs are deliberately ignored until the dead interval expires.
          if (dead_r[ch] == DEAD_LAST) begin
            state_s[ch] = ST_IDLE;
            dead_s[ch]  = {DEAD_W{1'b0}};
          end else begin
            dead_s[ch] = dead_r[ch] + DEAD_W'(1);
          end
        end
        default: begin
          state_s[ch] = ST_IDLE;
          duty_s[ch]  = {PWM_BITS{1'b0}};
          presc_s[ch] = {PRESC_W{1'b0}};
          dead_s[ch]  = {DEAD_W{1'b0}};
        end
      endcase

      drive_s = (state_s[ch] == ST_RAMP) || (state_s[ch] == ST_RUN);
      if (drive_s) begin
        hb_dir_s[2*ch +: 2] = dir_s[ch];
        hb_pwm_s[ch]        = (pwm_cnt_r < duty_act_r[ch]);
        if (pwm_cnt_r == PWM_TOP) begin
          duty_act_s[ch] = duty_r[ch];
        end else begin
          duty_act_s[ch] = duty_act_r[ch];
        end
      end else begin
        // Bridge off: coast, no pulse, shadow cleared without waiting for wrap.
        hb_dir_s[2*ch +: 2] = 2'b00;
        hb_pwm_s[ch]        = 1'b0;
        duty_act_s[ch]      = {PWM_BITS{1'b0}};
      end
    end
  end

  // Channel state, duty, counters and registered bridge outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int ch = 0; ch < 2; ch++) begin
        state_r[ch]    <= ST_IDLE;
        dir_r[ch]      <= 2'b00;
        duty_r[ch]     <= {PWM_BITS{1'b0}};
        presc_r[ch]    <= {PRESC_W{1'b0}};
        dead_r[ch]     <= {DEAD_W{1'b0}};
        duty_act_r[ch] <= {PWM_BITS{1'b0}};
      end
      hb_dir_r <= 4'b0000;
      hb_pwm_r <= 2'b00;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        state_r[ch]    <= state_s[ch];
        dir_r[ch]      <= dir_s[ch];
        duty_r[ch]     <= duty_s[ch];
        presc_r[ch]    <= presc_s[ch];
        dead_r[ch]     <= dead_s[ch];
        duty_act_r[ch] <= duty_act_s[ch];
      end
      hb_dir_r <= hb_dir_s;
      hb_pwm_r <= hb_pwm_s;
    end
  end

  assign hb_dir   = hb_dir_r;
  assign hb_pwm   = hb_pwm_r;
  assign ch_state = {state_r[1], state_r[0]};

endmodule

// File: tb/tb_hbridge_pwm_driver.sv
// Scoreboard bench for hbridge_pwm_driver. The stimulus process drives random and
// targeted command sequences. A behavioural model pushes the expected outputs for
// each clock edge. Independent monitors pop the expectations and compare them.

module tb_hbridge_pwm_driver;

  localparam int PB   = 8;
  localparam int DMAX = 192;
  localparam int STEP = 64;
  localparam int DIV  = 2;
  localparam int DEAD = 4;
  localparam int PER  = 1 << PB;

  localparam int M_IDLE = 0;
  localparam int M_RAMP = 1;
  localparam int M_RUN  = 2;
  localparam int M_DEAD = 3;

  logic       clk;
  logic       rst_n;
  logic [3:0] motor_in;
  logic [1:0] motor_en;
  logic [3:0] hb_dir;
  logic [1:0] hb_pwm;
  logic [3:0] ch_state;

  hbridge_pwm_driver #(
    .PWM_BITS(PB), .DUTY_MAX(DMAX), .RAMP_STEP(STEP),
    .RAMP_DIV(DIV), .DEAD_CYCLES(DEAD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .motor_in(motor_in), .motor_en(motor_en),
    .hb_dir(hb_dir), .hb_pwm(hb_pwm), .ch_state(ch_state)
  );

  typedef struct {
    logic [9:0] v;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t async_q[$];
  int   tests = 0;
  int   fails = 0;
  string phase = "reset";

  // Behavioural model: mode per channel, with the duty derived from completed ramp ticks.
  int         m_mode   [2];
  logic [1:0] m_dir    [2];
  int         m_ticks  [2];
  int         m_sub    [2];
  int         m_dead   [2];
  int         m_shadow [2];
  int         m_cnt;
  logic [3:0] m_s1_in, m_s2_in;
  logic [1:0] m_s1_en, m_s2_en;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int duty_of(input int mode, input int ticks);
    if (mode == M_RUN) return DMAX;
    if (mode == M_RAMP) return (ticks * STEP > DMAX) ? DMAX : ticks * STEP;
    return 0;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_mode[c] = M_IDLE; m_dir[c] = 2'b00; m_ticks[c] = 0;
      m_sub[c] = 0; m_dead[c] = 0; m_shadow[c] = 0;
    end
    m_cnt = 0;
    m_s1_in = 4'b0000; m_s2_in = 4'b0000;
    m_s1_en = 2'b00;   m_s2_en = 2'b00;
  endtask

  // Advance the model by one clock edge. The result is {hb_dir, hb_pwm, ch_state}.
  task automatic model_step(input logic rn, output logic [9:0] res);
    int old_cnt;
    int old_duty [2];
    int old_shadow [2];
    logic [1:0] pair;
    logic en;
    logic [3:0] e_dir;
    logic [1:0] e_pwm;
    logic [3:0] e_st;
    if (!rn) begin
      model_reset();
      res = 10'b0;
      return;
    end
    old_cnt = m_cnt;
    for (int c = 0; c < 2; c++) begin
      old_duty[c]   = duty_of(m_mode[c], m_ticks[c]);
      old_shadow[c] = m_shadow[c];
    end
    e_dir = 4'b0000; e_pwm = 2'b00; e_st = 4'b0000;
    for (int c = 0; c < 2; c++) begin
      pair = m_s2_in[2*c +: 2];
      en   = m_s2_en[c];
      if (m_mode[c] == M_IDLE) begin
        if (en && (pair == 2'b10 || pair == 2'b01)) begin
          m_mode[c] = M_RAMP; m_dir[c] = pair; m_ticks[c] = 0; m_sub[c] = 0;
        end
      end else if (m_mode[c] == M_DEAD) begin
        m_dead[c]++;
        if (m_dead[c] == DEAD) m_mode[c] = M_IDLE;
      end else if (!en || pair != m_dir[c]) begin
        m_mode[c] = M_DEAD; m_dead[c] = 0; m_ticks[c] = 0; m_sub[c] = 0;
      end else if (m_mode[c] == M_RAMP) begin
        m_sub[c]++;
        if (m_sub[c] == DIV) begin
          m_sub[c] = 0;
          m_ticks[c]++;
          if (m_ticks[c] * STEP >= DMAX) m_mode[c] = M_RUN;
        end
      end
      if (m_mode[c] == M_RAMP || m_mode[c] == M_RUN) begin
        e_dir[2*c +: 2] = m_dir[c];
        e_pwm[c] = (old_cnt < old_shadow[c]);
        if (old_cnt == PER - 1) m_shadow[c] = old_duty[c];
      end else begin
        m_shadow[c] = 0;
      end
      e_st[2*c +: 2] = 2'(m_mode[c]);
    end
    m_cnt = (old_cnt + 1) % PER;
    m_s2_in = m_s1_in; m_s1_in = motor_in;
    m_s2_en = m_s1_en; m_s1_en = motor_en;
    res = {e_dir, e_pwm, e_st};
  endtask

  task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got dir=%b pwm=%b state=%b, expected dir=%b pwm=%b state=%b",
               name, $time, got[9:6], got[5:4], got[3:0], exp[9:6], exp[5:4], exp[3:0]);
    end
  endtask

  // Drive a command for n cycles at the falling edge and queue the expected response.
  task automatic drive(input logic [3:0] mi, input logic [1:0] me, input logic rn, input int n);
    logic [9:0] e;
    exp_t item;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      motor_in = mi;
      motor_en = me;
      if (!rn && rst_n) begin
        item.v = 10'b0; item.tag = {phase, "_async_rst"};
        async_q.push_back(item);
        model_reset();
      end
      rst_n = rn;
      model_step(rn, e);
      item.v = e; item.tag = phase;
      exp_q.push_back(item);
    end
  endtask

  // Clocked monitor: one expectation per rising edge, sampled just after it.
  initial begin
    exp_t it;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        it = exp_q.pop_front();
        check(it.tag, {hb_dir, hb_pwm, ch_state}, it.v);
      end
    end
  end

  // Asynchronous reset monitor: outputs must clear without any clock edge.
  initial begin
    exp_t it;
    forever begin
      @(negedge rst_n);
      #1;
      if (async_q.size() > 0) begin
        it = async_q.pop_front();
        check(it.tag, {hb_dir, hb_pwm, ch_state}, it.v);
      end
    end
  end

  initial begin
    logic [3:0] mi;
    logic [1:0] me;
    rst_n    = 1'b0;
    motor_in = 4'b1010;
    motor_en = 2'b11;
    model_reset();

    phase = "reset";        drive(4'b1010, 2'b11, 1'b0, 4);
    phase = "ramp_run";     drive(4'b1010, 2'b11, 1'b1, 600);
    phase = "reversal_a";   drive(4'b0110, 2'b11, 1'b1, 600);
    phase = "disable_b";    drive(4'b0110, 2'b10, 1'b1, 40);
    phase = "reenable_b";   drive(4'b0110, 2'b11, 1'b1, 300);
    phase = "glitch_b";     drive(4'b0111, 2'b11, 1'b1, 1);
    phase = "dead_ignore";  drive(4'b0110, 2'b11, 1'b1, 300);
    phase = "to_dead";      drive(4'b0110, 2'b00, 1'b1, 5);
    phase = "rst_mid_dead"; drive(4'b0110, 2'b00, 1'b0, 3);
    phase = "restart";      drive(4'b1001, 2'b11, 1'b1, 40);

    phase = "random";
    for (int s = 0; s < 40; s++) begin
      mi = 4'($urandom);
      me = 2'($urandom);
      if ($urandom_range(0, 9) == 0) drive(mi, me, 1'b0, 1);
      drive(mi, me, 1'b1, $urandom_range(1, 60));
      if ($urandom_range(0, 3) == 0) drive(mi, me, 1'b1, 300);
    end

    @(posedge clk);
    #3;
    tests++;
    if (exp_q.size() != 0 || async_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d clocked and %0d async expectations left, required 0",
               exp_q.size(), async_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
